// File: rtl/uno_card_renderer.sv
// UNO card renderer: maps timing-generator counters to a 24-bit RGB pixel.
// Card contents live in a shadow register file that is copied to the active
// copy once per frame at counter (0,0). Three-stage pipeline:
// decode -> glyph ROM row latch -> colour mux.
module uno_card_renderer #(
   parameter int unsigned H_BLANK = 160,
   parameter int unsigned V_BLANK = 45
) (
   input  logic            i_clk_25M,
   input  logic            i_rst,
   input  logic [9:0]      i_x_cnt,
   input  logic [9:0]      i_y_cnt,
   input  logic            i_card_we,
   input  logic [3:0]      i_card_slot,
   input  logic [5:0]      i_card_code,
   input  logic [3:0]      i_sel_slot,
   output logic [7:0]      o_glyph_addr,
   input  logic [7:0]      i_glyph_row,
   output logic [2:0][7:0] o_pixel,
   output logic            o_frame_commit
);
   localparam logic [5:0]  EMPTY = 6'h3F;
   localparam logic [10:0] X_LO  = 11'(H_BLANK);
   localparam logic [10:0] X_HI  = 11'(H_BLANK + 640);
   localparam logic [10:0] Y_LO  = 11'(V_BLANK);
   localparam logic [10:0] Y_HI  = 11'(V_BLANK + 480);

   // Pixel constants packed as {B, G, R} so that o_pixel[0] is red.
   localparam logic [23:0] C_BG     = 24'h206000;
   localparam logic [23:0] C_BLACK  = 24'h000000;
   localparam logic [23:0] C_MAG    = 24'hFF00FF;
   localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
   localparam logic [23:0] C_RED    = 24'h0000FF;
   localparam logic [23:0] C_YELLOW = 24'h00D0FF;
   localparam logic [23:0] C_GREEN  = 24'h00A000;
   localparam logic [23:0] C_BLUE   = 24'hFF4000;

   typedef struct packed {
      logic       valid;
      logic       card;
      logic       border;
      logic       glyph;
      logic [2:0] gcol;
      logic [1:0] col;
      logic       sel;
   } dec_t;

   logic [5:0] shd_q [9];
   logic [5:0] shd_d [9];
   logic [5:0] act_q [9];
   logic [5:0] act_d [9];
   logic [3:0] sel_shd_q, sel_shd_d, sel_act_q, sel_act_d;
   logic       commit_q, commit_d;

   logic [9:0] px, py, x0, y0;
   logic       in_act, hit;
   logic [3:0] hit_slot;
   logic [5:0] code;
   logic [5:0] lx;
   logic [6:0] ly;

   dec_t        s1_q, s1_d, s2_q, s2_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  row_q, row_d;
   logic [23:0] pixel_q, pixel_d, colour;

   // Shadow/active register files; a write in the commit cycle stays in shadow.
   always_comb begin
      shd_d     = shd_q;
      act_d     = act_q;
      sel_shd_d = i_sel_slot;
      sel_act_d = sel_act_q;
      commit_d  = (i_x_cnt == '0) && (i_y_cnt == '0);
      if (commit_d) begin
         act_d     = shd_q;
         sel_act_d = sel_shd_q;
      end
      if (i_card_we && (i_card_slot <= 4'd8)) begin
         shd_d[i_card_slot] = i_card_code;
      end
   end

   // Stage 1: region decode from the raw counters against the active copy.
   always_comb begin
      px       = i_x_cnt - 10'(H_BLANK);
      py       = i_y_cnt - 10'(V_BLANK);
      in_act   = ({1'b0, i_x_cnt} >= X_LO) && ({1'b0, i_x_cnt} < X_HI) &&
                 ({1'b0, i_y_cnt} >= Y_LO) && ({1'b0, i_y_cnt} < Y_HI);
      hit      = 1'b0;
      hit_slot = 4'hF;
      x0       = '0;
      y0       = '0;
      if (in_act && (py >= 10'd360) && (py <= 10'd455)) begin
         for (int unsigned s = 0; s < 8; s++) begin
            if ((px >= 10'(s * 80 + 8)) && (px <= 10'(s * 80 + 71))) begin
               hit      = 1'b1;
               hit_slot = 4'(s);
               x0       = 10'(s * 80 + 8);
            end
         end
         y0 = 10'd360;
      end else if (in_act && (px >= 10'd288) && (px <= 10'd351) &&
                   (py >= 10'd160) && (py <= 10'd255)) begin
         hit      = 1'b1;
         hit_slot = 4'd8;
         x0       = 10'd288;
         y0       = 10'd160;
      end
      code = hit ? act_q[hit_slot] : EMPTY;
      lx   = 6'(px - x0);
      ly   = 7'(py - y0);

      s1_d        = '0;
      s1_d.valid  = in_act;
      s1_d.card   = hit && (code != EMPTY);
      s1_d.border = (lx < 6'd2) || (lx > 6'd61) || (ly < 7'd2) || (ly > 7'd93);
      s1_d.glyph  = s1_d.card && (code[3:0] != 4'hF) &&
                    (lx >= 6'd16) && (lx <= 6'd47) && (ly >= 7'd32) && (ly <= 7'd63);
      s1_d.gcol   = 3'((lx - 6'd16) >> 2);
      s1_d.col    = code[5:4];
      s1_d.sel    = (hit_slot == sel_act_q);
      addr_d      = s1_d.glyph ? {code[3:0], 1'b0, 3'((ly - 7'd32) >> 2)} : '0;
   end

   // Stage 2 carries the decode alongside the ROM row; stage 3 picks the colour.
   always_comb begin
      s2_d  = s1_q;
      row_d = i_glyph_row;
      case (s2_q.col)
         2'd0:    colour = C_RED;
         2'd1:    colour = C_YELLOW;
         2'd2:    colour = C_GREEN;
         default: colour = C_BLUE;
      endcase
      pixel_d = '0;
      if (s2_q.valid) begin
         if (!s2_q.card)                                pixel_d = C_BG;
         else if (s2_q.border)                          pixel_d = s2_q.sel ? C_MAG : C_BLACK;
         else if (s2_q.glyph && row_q[3'd7 - s2_q.gcol]) pixel_d = colour;
         else                                           pixel_d = C_WHITE;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk_25M) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < 9; i++) begin
            shd_q[i] <= EMPTY;
            act_q[i] <= EMPTY;
         end
         sel_shd_q <= 4'hF;
         sel_act_q <= 4'hF;
         commit_q  <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         addr_q    <= '0;
         row_q     <= '0;
         pixel_q   <= '0;
      end else begin
         shd_q     <= shd_d;
         act_q     <= act_d;
         sel_shd_q <= sel_shd_d;
         sel_act_q <= sel_act_d;
         commit_q  <= commit_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         addr_q    <= addr_d;
         row_q     <= row_d;
         pixel_q   <= pixel_d;
      end
   end

   assign o_glyph_addr   = addr_q;
   assign o_pixel        = pixel_q;
   assign o_frame_commit = commit_q;
endmodule

// File: tb/tb_uno_card_renderer.sv
// Bench for uno_card_renderer: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the card layout.
module tb_uno_card_renderer;
   localparam int HB = 160;
   localparam int VB = 45;

   localparam logic [23:0] BG    = 24'h206000;
   localparam logic [23:0] BLK   = 24'h000000;
   localparam logic [23:0] MAG   = 24'hFF00FF;
   localparam logic [23:0] WHT   = 24'hFFFFFF;
   localparam logic [23:0] RED   = 24'h0000FF;
   localparam logic [23:0] GRN   = 24'h00A000;

   logic            clk = 1'b0;
   logic            rst;
   logic [9:0]      x_cnt, y_cnt;
   logic            we;
   logic [3:0]      wslot;
   logic [5:0]      wcode;
   logic [3:0]      sel;
   logic [7:0]      gaddr;
   logic [7:0]      grow;
   logic [2:0][7:0] pix;
   logic            fcommit;

   logic [7:0] rom [256];
   assign grow = rom[gaddr];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uno_card_renderer #(.H_BLANK(HB), .V_BLANK(VB)) dut (
      .i_clk_25M     (clk),
      .i_rst         (rst),
      .i_x_cnt       (x_cnt),
      .i_y_cnt       (y_cnt),
      .i_card_we     (we),
      .i_card_slot   (wslot),
      .i_card_code   (wcode),
      .i_sel_slot    (sel),
      .o_glyph_addr  (gaddr),
      .i_glyph_row   (grow),
      .o_pixel       (pix),
      .o_frame_commit(fcommit)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [5:0]  m_sh  [9];
   logic [5:0]  m_act [9];
   logic [3:0]  m_sel_sh, m_sel_act;
   logic [23:0] p1, p2, p3;
   logic [7:0]  exp_addr;
   logic        exp_commit;
   bit          chk_en = 1'b0;

   function automatic void locate(input int x, input int y, output bit act,
                                  output int slot, output int lx, output int ly);
      int px, py;
      px   = x - HB;
      py   = y - VB;
      act  = (px >= 0) && (px < 640) && (py >= 0) && (py < 480);
      slot = -1;
      lx   = 0;
      ly   = 0;
      if (act) begin
         if (py >= 360 && py <= 455 && (px % 80) >= 8 && (px % 80) <= 71) begin
            slot = px / 80;
            lx   = px % 80 - 8;
            ly   = py - 360;
         end else if (px >= 288 && px <= 351 && py >= 160 && py <= 255) begin
            slot = 8;
            lx   = px - 288;
            ly   = py - 160;
         end
      end
   endfunction

   function automatic bit in_box(input int slot, input int lx, input int ly);
      logic [5:0] c;
      if (slot < 0) return 1'b0;
      c = m_act[slot];
      return (c != 6'h3F) && (c[3:0] != 4'hF) && lx >= 16 && lx <= 47 && ly >= 32 && ly <= 63;
   endfunction

   function automatic logic [7:0] model_addr(input int x, input int y);
      bit act; int slot, lx, ly;
      locate(x, y, act, slot, lx, ly);
      if (!in_box(slot, lx, ly)) return 8'h00;
      return 8'(int'(m_act[slot][3:0]) * 16 + (ly - 32) / 4);
   endfunction

   function automatic logic [23:0] model_pix(input int x, input int y);
      bit act; int slot, lx, ly;
      logic [5:0] c;
      logic [7:0] r;
      locate(x, y, act, slot, lx, ly);
      if (!act) return 24'h0;
      if (slot < 0) return BG;
      c = m_act[slot];
      if (c == 6'h3F) return BG;
      if (lx < 2 || lx > 61 || ly < 2 || ly > 93)
         return (slot == int'(m_sel_act)) ? MAG : BLK;
      if (in_box(slot, lx, ly)) begin
         r = rom[model_addr(x, y)];
         if (r[7 - (lx - 16) / 4]) begin
            case (c[5:4])
               2'd0:    return RED;
               2'd1:    return 24'h00D0FF;
               2'd2:    return GRN;
               default: return 24'hFF4000;
            endcase
         end
      end
      return WHT;
   endfunction

   // Model state and a 3-deep expected-pixel delay line, both cleared by reset.
   always @(posedge clk) begin
      logic [23:0] e;
      logic [7:0]  a;
      logic        c;
      if (rst) begin
         e = '0; a = '0; c = 1'b0;
         for (int i = 0; i < 9; i++) begin
            m_sh[i]  <= 6'h3F;
            m_act[i] <= 6'h3F;
         end
         m_sel_sh  <= 4'hF;
         m_sel_act <= 4'hF;
      end else begin
         e = model_pix(int'(x_cnt), int'(y_cnt));
         a = model_addr(int'(x_cnt), int'(y_cnt));
         c = (x_cnt == 10'd0) && (y_cnt == 10'd0);
         if (c) begin
            for (int i = 0; i < 9; i++) m_act[i] <= m_sh[i];
            m_sel_act <= m_sel_sh;
         end
         if (we && wslot <= 4'd8) m_sh[wslot] <= wcode;
         m_sel_sh <= sel;
      end
      p1         <= e;
      p2         <= rst ? 24'h0 : p1;
      p3         <= rst ? 24'h0 : p2;
      exp_addr   <= a;
      exp_commit <= c;
      chk_en     <= 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pixel", 32'(pix), 32'(p3));
         check("glyph_addr", 32'(gaddr), 32'(exp_addr));
         check("frame_commit", 32'(fcommit), 32'(exp_commit));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] s, input logic [5:0] c);
      we = 1'b1; wslot = s; wcode = c;
      step();
      we = 1'b0;
   endtask

   task automatic commit();
      x_cnt = 10'd0; y_cnt = 10'd0;
      step();
      x_cnt = 10'd1; y_cnt = 10'd1;
      check("commit_pulse", 32'(fcommit), 32'd1);
   endtask

   task automatic present_chk(input int x, input int y, input logic [23:0] exp, input string nm,
                              input bit do_addr, input logic [7:0] exp_a);
      x_cnt = 10'(x); y_cnt = 10'(y);
      step();
      if (do_addr) check({nm, "_addr"}, 32'(gaddr), 32'(exp_a));
      x_cnt = 10'd1; y_cnt = 10'd1;
      step();
      step();
      check(nm, 32'(pix), 32'(exp));
   endtask

   initial begin
      int r, s;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[8'h70] = 8'hFF;
      rom[8'h74] = 8'h00;
      rom[8'h10] = 8'h80;
      rst = 1'b1; x_cnt = 10'd1; y_cnt = 10'd1;
      we = 1'b0; wslot = '0; wcode = '0; sel = 4'hF;
      step();
      step();
      rst = 1'b0;
      check("rst_pixel", 32'(pix), 32'd0);
      check("rst_addr", 32'(gaddr), 32'd0);
      check("rst_commit", 32'(fcommit), 32'd0);
      present_chk(468, 255, BG, "empty_after_reset", 1'b0, 8'h00);

      // write discard red 7: invisible until commit
      wr(4'd8, 6'h07);
      present_chk(468, 255, BG, "pre_commit_bg", 1'b0, 8'h00);
      commit();
      present_chk(468, 255, WHT, "discard_white", 1'b1, 8'h74);
      present_chk(468, 239, RED, "discard_glyph_red", 1'b1, 8'h70);

      // border with highlight, then without
      sel = 4'd0;
      wr(4'd0, 6'h31);
      commit();
      present_chk(168, 405, MAG, "border_sel", 1'b0, 8'h00);
      sel = 4'hF;
      step();
      commit();
      present_chk(168, 405, BLK, "border_nosel", 1'b0, 8'h00);

      // latency and ROM address
      wr(4'd0, 6'h21);
      commit();
      present_chk(184, 437, GRN, "glyph_green", 1'b1, 8'h10);

      // write in the commit cycle lands one frame late
      x_cnt = 10'd0; y_cnt = 10'd0; we = 1'b1; wslot = 4'd3; wcode = 6'h12;
      step();
      we = 1'b0; x_cnt = 10'd1; y_cnt = 10'd1;
      present_chk(438, 415, BG, "collision_hidden", 1'b0, 8'h00);
      commit();
      present_chk(438, 415, WHT, "collision_visible", 1'b0, 8'h00);
      wr(4'd12, 6'h00);
      commit();
      present_chk(438, 415, WHT, "slot12_ignored_s3", 1'b0, 8'h00);
      present_chk(468, 255, WHT, "slot12_ignored_s8", 1'b0, 8'h00);

      // value 15 and empty code
      wr(4'd5, 6'h0F);
      commit();
      present_chk(588, 445, WHT, "v15_no_glyph", 1'b1, 8'h00);
      present_chk(568, 405, BLK, "v15_border", 1'b0, 8'h00);
      wr(4'd5, 6'h3F);
      commit();
      present_chk(568, 405, BG, "empty_border_bg", 1'b0, 8'h00);
      present_chk(588, 445, BG, "empty_inner_bg", 1'b0, 8'h00);
      present_chk(150, 100, 24'h0, "blank_black", 1'b0, 8'h00);

      // randomized run, checked by the model every cycle
      for (int n = 0; n < 20000; n++) begin
         rst = ($urandom_range(0, 1999) == 0);
         we  = ($urandom_range(0, 2) == 0);
         wslot = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
         wcode = ($urandom_range(0, 5) == 0) ? 6'h3F : 6'($urandom);
         if ($urandom_range(0, 19) == 0) sel = 4'($urandom);
         r = $urandom_range(0, 3);
         if ($urandom_range(0, 49) == 0) begin
            x_cnt = 10'd0; y_cnt = 10'd0;
         end else if (r == 0) begin
            x_cnt = 10'($urandom_range(0, 1023)); y_cnt = 10'($urandom_range(0, 1023));
         end else if (r == 1) begin
            x_cnt = 10'(HB + $urandom_range(0, 639)); y_cnt = 10'(VB + $urandom_range(355, 460));
         end else if (r == 2) begin
            x_cnt = 10'(HB + $urandom_range(280, 360)); y_cnt = 10'(VB + $urandom_range(150, 265));
         end else begin
            s = $urandom_range(0, 8);
            x_cnt = 10'(HB + ((s < 8) ? s * 80 + 8 : 288) + $urandom_range(14, 49));
            y_cnt = 10'(VB + ((s < 8) ? 360 : 160) + $urandom_range(30, 65));
         end
         step();
      end
      rst = 1'b0; we = 1'b0; x_cnt = 10'd1; y_cnt = 10'd1;
      step();
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uno_card_renderer.md
# uno_card_renderer

Pixel-source stage placed directly upstream of the VGA timing generator in the UNO display path. It takes the timing generator's raw horizontal/vertical counters and returns the 24-bit RGB pixel for that position, drawing a felt background, eight hand-card slots and one discard-pile card. Card contents come from the game controller through a shadow register file that is committed once per frame, which keeps a frame free of tearing. Value glyphs are read from an external synchronous glyph ROM through a fixed 3-cycle pipeline.

## Interface
- `H_BLANK`, default 160: first active counter column; pixel x = `i_x_cnt - H_BLANK`.
- `V_BLANK`, default 45: first active counter row; pixel y = `i_y_cnt - V_BLANK`.
- `i_clk_25M`, in, 1: pixel clock. All logic is on the rising edge.
- `i_rst`, in, 1: **one clock; reset is synchronous and active-high.**
- `i_x_cnt`, in, 10: horizontal counter from the timing generator. Active range is 160..799.
- `i_y_cnt`, in, 10: vertical counter. Active range is 45..524.
- `i_card_we`, in, 1: write strobe for the shadow card register.
- `i_card_slot`, in, 4: slot to write. 0..7 are hand slots, 8 is the discard pile, 9..15 are ignored.
- `i_card_code`, in, 6: card code. [5:4] is the colour (0 red, 1 yellow, 2 green, 3 blue), [3:0] is the value 0..14. The code 6'h3F means an empty slot.
- `i_sel_slot`, in, 4: highlighted slot, sampled into shadow every cycle. 9..15 mean no highlight.
- `o_glyph_addr`, out, 8: glyph ROM address `{value[3:0], 1'b0, row[2:0]}`.
- `i_glyph_row`, in, 8: ROM data, valid exactly 1 cycle after the address. Bit 7 is the leftmost column.
- `o_pixel[2:0]`, out, 3×8: [0] is R, [1] is G, [2] is B. Connects directly to the timing generator's pixel input.
- `o_frame_commit`, out, 1: one-cycle pulse when the shadow copy is committed to the active copy.

## Operation
- **Register files:** shadow and active copies, each 9×6-bit, plus a 4-bit select register in each copy.
  - A write with `i_card_we` and slot ≤ 8 updates the shadow copy only.
  - **Commit condition:** `i_x_cnt == 0 && i_y_cnt == 0`. On that cycle, active ← shadow and `o_frame_commit` pulses.
  - A shadow write in the commit cycle does not reach active until the next frame.
- **Layout (pixel coordinates px, py):**
  - Hand slot s (0..7): x from s·80+8 to s·80+71, y from 360 to 455.
  - Discard pile (slot 8): x 288..351, y 160..255.
  - Every card is 64×96. Card-local coordinates: lx = px − x0 (6 bit), ly = py − y0 (7 bit).
- **Pixel priority for an active-region pixel inside a non-empty slot:**
  1. Border, where lx<2, lx>61, ly<2 or ly>93: black 00,00,00. If the slot equals the active select register, magenta FF,00,FF instead.
  2. Glyph box, lx 16..47 and ly 32..63, with value ≤ 14: glyph row = (ly−32)>>2 and glyph column = (lx−16)>>2. A set bit draws the card colour; a clear bit draws white.
  3. Anything else: white FF,FF,FF.
- **Card colours:** red FF,00,00; yellow FF,D0,00; green 00,A0,00; blue 00,40,FF.
- **Special cases:**
  - Value 15 with a code other than 3F: blank white card with a border, no glyph.
  - An empty slot, or any active pixel outside every slot: background 00,60,20.
  - Counter outside the active range: o_pixel = 0,0,0.
- **Pipeline:**
  - Stage 1 registers the region decode (slot, in-card, border, in-glyph, glyph column, colour, select) and drives `o_glyph_addr`.
  - Stage 2 latches `i_glyph_row` and the stage-1 decode.
  - Stage 3 selects the bit, muxes the colour and registers `o_pixel`.

## Timing
- **Latency:** `o_pixel` reflects the counter pair presented exactly 3 cycles earlier. The timing generator offsets its counters by 3.
- **Pipeline rate:** fully pipelined, one pixel per cycle, no stalls, no handshake.
- **`o_glyph_addr` timing:** registered, so it changes 1 cycle after its counter pair. It is held at 0 when the stage-1 pixel is not in a glyph box.
- **Reset values:**
  - All shadow and active slots = 3F.
  - Both select registers = 4'hF.
  - Pipeline valid flags = 0.
  - `o_pixel` = 0,0,0.
  - `o_glyph_addr` = 0.
  - `o_frame_commit` = 0.
- **Reset mid-frame:** output is black from the next edge and stays black for 3 cycles after reset is released. Slots stay empty until writes land and a commit occurs.
- **Counter discontinuities:** no state depends on counter continuity. Any counter jump, including a wrap, is rendered correctly after 3 cycles.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles, then sweep one frame with no writes. Every active pixel is 00,60,20, every blank pixel is 0, and `o_frame_commit` pulses once at (0,0).
- **Write and commit:** write slot 8 = 6'h07 (red 7) mid-frame. The current frame still shows background at counter (160+288+20, 45+160+50). After the commit, the next frame shows white there and FF,00,00 at glyph-set pixels with ROM row = 8'hFF.
- **Border and select:** write slot 0 = 6'h31 (blue 1) and set sel = 0, then commit. Counter (168,405) gives FF,00,FF. Set sel = 15 and commit: the same pixel gives 00,00,00.
- **Latency and ROM address:** present (160+8+16, 45+360+32) with slot 0 = 6'h21. `o_glyph_addr` = 8'h10 one cycle later. Returning 8'h80 gives green 00,A0,00 at `o_pixel` exactly 3 cycles after the input.
- **Commit collision and invalid writes:** write slot 3 at the commit cycle. The change is visible only after the following commit. A write to slot 12 changes nothing.
- **Value 15 and empty code:** slot 5 = 6'h0F renders a plain white card with a border and no glyph. Slot 5 = 6'h3F renders background 00,60,20 across the whole slot area.
